// File: rtl/pipe_hazard_unit.sv
// Hazard unit for a 5-stage pipeline: tracks EX/MEM/WB destination tags, selects
// forwarding paths, and drives PC/IF-ID/pipeline enables plus stall/flush event counters.

module pipe_hazard_src #(
    parameter int REG_AW = 5
) (
    input  logic              ex_vld_i,
    input  logic [REG_AW-1:0] ex_src_i,
    input  logic              ex_used_i,
    input  logic              mem_fwd_i,
    input  logic [REG_AW-1:0] mem_dst_i,
    input  logic              wb_fwd_i,
    input  logic [REG_AW-1:0] wb_dst_i,
    input  logic              ex_ld_i,
    input  logic [REG_AW-1:0] ex_dst_i,
    input  logic              id_vld_i,
    input  logic [REG_AW-1:0] id_src_i,
    input  logic              id_used_i,
    output logic [1:0]        fwd_sel_o,
    output logic              id_bypass_o,
    output logic              load_use_o
);
    logic ex_rd, id_rd;

    // Register 0 is hard-wired, so a read of it never depends on anything in flight.
    assign ex_rd = ex_vld_i && ex_used_i && (ex_src_i != '0);
    assign id_rd = id_vld_i && id_used_i && (id_src_i != '0);

    always_comb begin
        fwd_sel_o = 2'b00;
        if (ex_rd && mem_fwd_i && (mem_dst_i == ex_src_i))
            fwd_sel_o = 2'b01;
        else if (ex_rd && wb_fwd_i && (wb_dst_i == ex_src_i))
            fwd_sel_o = 2'b10;
    end

    assign id_bypass_o = id_rd && wb_fwd_i && (wb_dst_i == id_src_i);
    assign load_use_o  = id_rd && ex_ld_i && (ex_dst_i == id_src_i);
endmodule

module pipe_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int NSRC   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [NSRC*REG_AW-1:0] id_src,
    input  logic [NSRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]      id_dst,
    input  logic                   id_wr,
    input  logic                   id_is_load,
    input  logic                   id_jump,
    input  logic                   ex_redirect,
    input  logic                   mem_busy,
    output logic                   pc_we,
    output logic                   ifid_we,
    output logic                   pipe_en,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic [2*NSRC-1:0]      fwd_sel,
    output logic [NSRC-1:0]        id_bypass,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);
    localparam int STAGES = 3;

    typedef struct packed {
        logic              wr;
        logic              load;
        logic [REG_AW-1:0] dst;
    } tag_t;

    // vld_pipe bit 0 = EX, 1 = MEM, 2 = WB
    logic [STAGES-1:0]              vld_pipe_q, vld_pipe_d;
    tag_t                           ex_tag_q, ex_tag_d, mem_tag_q, mem_tag_d;
    logic                           wb_wr_q, wb_wr_d;
    logic [REG_AW-1:0]              wb_dst_q, wb_dst_d;
    logic [NSRC-1:0][REG_AW-1:0]    ex_src_q, ex_src_d;
    logic [NSRC-1:0]                ex_used_q, ex_used_d;
    logic [CNT_W-1:0]               stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic [NSRC-1:0][REG_AW-1:0]    id_src_v;
    logic [NSRC-1:0][1:0]           fwd_v;
    logic [NSRC-1:0]                lu_v;
    logic                           mem_fwd, wb_fwd, ex_ld, load_use;
    logic                           stall_ev, flush_ev;

    assign id_src_v = id_src;
    assign fwd_sel  = fwd_v;
    assign mem_fwd  = vld_pipe_q[1] && mem_tag_q.wr && !mem_tag_q.load;
    assign wb_fwd   = vld_pipe_q[2] && wb_wr_q;
    assign ex_ld    = vld_pipe_q[0] && ex_tag_q.wr && ex_tag_q.load;

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        pipe_hazard_src #(.REG_AW(REG_AW)) u_src (
            .ex_vld_i    (vld_pipe_q[0]),
            .ex_src_i    (ex_src_q[k]),
            .ex_used_i   (ex_used_q[k]),
            .mem_fwd_i   (mem_fwd),
            .mem_dst_i   (mem_tag_q.dst),
            .wb_fwd_i    (wb_fwd),
            .wb_dst_i    (wb_dst_q),
            .ex_ld_i     (ex_ld),
            .ex_dst_i    (ex_tag_q.dst),
            .id_vld_i    (id_valid),
            .id_src_i    (id_src_v[k]),
            .id_used_i   (id_src_used[k]),
            .fwd_sel_o   (fwd_v[k]),
            .id_bypass_o (id_bypass[k]),
            .load_use_o  (lu_v[k])
        );
    end

    assign load_use = |lu_v;

    // Reset forces the free-running defaults regardless of the request inputs.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        pipe_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;
        if (!reset) begin
            if (mem_busy) begin
                pipe_en = 1'b0;
                pc_we   = 1'b0;
                ifid_we = 1'b0;
            end else if (ex_redirect) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                flush_ev    = 1'b1;
            end else if (load_use) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                stall_ev    = 1'b1;
            end else if (id_jump) begin
                ifid_flush = 1'b1;
                flush_ev   = 1'b1;
            end
        end
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        ex_tag_d   = ex_tag_q;
        mem_tag_d  = mem_tag_q;
        wb_wr_d    = wb_wr_q;
        wb_dst_d   = wb_dst_q;
        ex_src_d   = ex_src_q;
        ex_used_d  = ex_used_q;
        if (pipe_en) begin
            vld_pipe_d = {vld_pipe_q[STAGES-2:0], id_valid && !idex_bubble};
            ex_tag_d   = '{wr: id_wr, load: id_is_load, dst: id_dst};
            mem_tag_d  = ex_tag_q;
            wb_wr_d    = mem_tag_q.wr;
            wb_dst_d   = mem_tag_q.dst;
            ex_src_d   = id_src_v;
            ex_used_d  = id_src_used;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_ev && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_ev && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q  <= '0;
            ex_tag_q    <= '0;
            mem_tag_q   <= '0;
            wb_wr_q     <= 1'b0;
            wb_dst_q    <= '0;
            ex_src_q    <= '0;
            ex_used_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            ex_tag_q    <= ex_tag_d;
            mem_tag_q   <= mem_tag_d;
            wb_wr_q     <= wb_wr_d;
            wb_dst_q    <= wb_dst_d;
            ex_src_q    <= ex_src_d;
            ex_used_q   <= ex_used_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule
